// File: rtl/mem_bus_pkg.sv
// Shared bus-responder definitions: FSM state encoding and wait-state limits,
// reused by both the responder and the CPU-side initiator.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam int MAX_WAIT_STATES = 7;
  localparam int WAIT_CNT_W      = 3;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word array with registered read; contents are never reset.
module mem_responder_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder on a shared tri-state data bus.
// Define MEM_RESPONDER_ERR_EN to add the sticky err output for bad requests.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int BASE        = 0,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [29:0] memaddr,
  inout  wire  [31:0] memdata,
  output logic        mem_ready
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int                    TAG_W     = 30 - DEPTH_LOG2;
  localparam logic [TAG_W-1:0]      BASE_TAG  = TAG_W'(BASE);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  mem_state_e             r_state, w_state_next;
  logic [WAIT_CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0]  r_addr;
  logic                   r_is_write;

  logic                   w_sel, w_rd_only, w_wr_only, w_accept, w_hold;
  logic                   w_ram_we, w_ram_re, w_drive;
  logic [DEPTH_LOG2-1:0]  w_ram_addr;
  logic [31:0]            w_rdata;

  assign w_sel     = (memaddr[29:DEPTH_LOG2] == BASE_TAG);
  assign w_rd_only = mem_re & ~mem_we;
  assign w_wr_only = mem_we & ~mem_re;
  assign w_accept  = (r_state == ST_IDLE) & w_sel & (w_rd_only | w_wr_only);
  // The strobe that opened the transaction must stay alone and high, else abort.
  assign w_hold    = r_is_write ? w_wr_only : w_rd_only;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_state_next = ST_RESP;
            w_cnt_next   = '0;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_hold) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt <= WAIT_CNT_W'(1)) begin
          w_state_next = ST_RESP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= memaddr[DEPTH_LOG2-1:0];
        r_is_write <= w_wr_only;
      end
    end
  end

  // With zero wait states RESP is entered straight from IDLE, before r_addr is loaded.
  assign w_ram_addr = (r_state == ST_IDLE) ? memaddr[DEPTH_LOG2-1:0] : r_addr;
  assign w_ram_re   = (w_state_next == ST_RESP);
  assign w_ram_we   = (r_state == ST_RESP) & r_is_write;

  mem_responder_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (memdata),
    .o_rdata (w_rdata)
  );

  assign w_drive   = (r_state == ST_RESP) & ~r_is_write & w_rd_only;
  assign memdata   = w_drive ? w_rdata : {32{1'bz}};
  assign mem_ready = (r_state == ST_RESP);

`ifdef MEM_RESPONDER_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && (mem_re || mem_we) &&
                 (!w_sel || (mem_re && mem_we))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter BASE, default 0, meaning the value memaddr[29:DEPTH_LOG2] must equal for the block to be selected.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning the number of idle cycles between request acceptance and response.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port mem_re, input, 1, read request from the bus initiator.
REQ-007 SHALL have port mem_we, input, 1, write request from the bus initiator.
REQ-008 SHALL have port memaddr, input, 30, word address.
REQ-009 SHALL have port memdata, inout, 32, shared data bus, tri-stated whenever the block is not driving it.
REQ-010 SHALL have port mem_ready, output, 1, one-cycle pulse marking read data valid or write committed.

Function
REQ-011 SHALL select a request only when memaddr[29:DEPTH_LOG2]==BASE; unselected requests cause no write, no drive and no mem_ready.
REQ-012 SHALL treat mem_re and mem_we both high as no request; the FSM stays in or returns to IDLE.
REQ-013 SHALL implement the states IDLE, WAIT, RESP.
- IDLE: latch the address and direction on a selected request, then go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
- WAIT: count down from WAIT_STATES; go to RESP after the final wait cycle.
- RESP: go to IDLE after one cycle.
REQ-014 SHALL hold the latched address constant from acceptance until return to IDLE; later memaddr changes are ignored.
REQ-015 SHALL abort to IDLE without write, drive or mem_ready if the requesting strobe deasserts in WAIT or in the cycle entering RESP.
REQ-016 For a read, SHALL register the array word at latched address bits [DEPTH_LOG2-1:0] on entry to RESP, then drive it on memdata and pulse mem_ready during RESP.
REQ-017 For a write, SHALL sample memdata on the rising clk that ends RESP and commit it to the array, with mem_ready high during that RESP cycle.
REQ-018 SHALL drive memdata only in RESP of a read with mem_re high and mem_we low; it SHALL be high-Z in every other case.
REQ-019 SHALL give total read latency WAIT_STATES+1 cycles from the acceptance edge to data valid.
REQ-020 SHALL require a new request to arrive after one IDLE cycle; a strobe held through RESP is not re-accepted until it is seen in IDLE.

Reset
REQ-021 While rst is low, SHALL force state=IDLE, wait counter=0, mem_ready=0, memdata high-Z, and the error flag (when built) =0; array contents are not reset.
REQ-022 Reset asserted mid-transaction SHALL abandon it; no array write occurs.

Configuration
REQ-023 With MEM_RESPONDER_ERR_EN defined:
- SHALL add output err (1 bit), a sticky flag.
- err SHALL set on any strobe seen in IDLE that is unselected or has both strobes high.
- err SHALL clear only on reset.
REQ-024 Without MEM_RESPONDER_ERR_EN, the err port and its logic SHALL be absent; function is otherwise identical.

Structure
REQ-025 SHALL place the FSM state encoding typedef and the WAIT_STATES upper bound constant in shared package mem_bus_pkg, for reuse by the CPU side.
REQ-026 SHALL use one sub-module, mem_responder_ram: a single-port synchronous word array with registered read.

Verification
REQ-027 Read, WAIT_STATES=1: preload word 5 = 32'hDEADBEEF; mem_re=1, memaddr=5 -> memdata=32'hDEADBEEF and mem_ready=1 exactly 2 cycles after acceptance; high-Z before and after.
REQ-028 Write-then-read: mem_we=1, memaddr=3, memdata=32'h12345678 through RESP -> a later read of address 3 returns 32'h12345678.
REQ-029 Abort: mem_re deasserted during WAIT -> no mem_ready and memdata never driven; a write aborted in WAIT leaves the old word unchanged.
REQ-030 Decode: BASE=1, DEPTH_LOG2=10, memaddr=30'h5 -> no response; err=1 when MEM_RESPONDER_ERR_EN is defined.
REQ-031 Both strobes high at memaddr=7 -> no drive, no write, FSM stays IDLE.
REQ-032 rst pulsed low during WAIT of a write -> state IDLE, mem_ready=0, target word unchanged.
